pen_locator: RTL

Light-pen position decoder for the 8x8 handwriting matrix. It watches the pixel-scan strobes that the LED matrix driver sends to the panel, and the raw light-pen `we` pulse. It turns each pen detection into a confirmed (row, col) coordinate. It sits between the matrix driver (scan source) and the frame-buffer write logic, which consumes `pos_valid`/`pos_row`/`pos_col` in DRAW/WRITE/ERASE modes.

---
 rtl/pen_locator.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pen_locator.sv
// rtl/pen_locator.sv - light-pen position decoder for the 8x8 handwriting matrix
module pen_locator #(
    parameter int LAT_MIN = 4,
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       we_i,
    input  logic [7:0] scan_row_n_i,
    input  logic [7:0] scan_col_i,
    output logic [2:0] pos_row_o,
    output logic [2:0] pos_col_o,
    output logic       pos_valid_o,
    output logic       pen_present_o
);

    localparam int AW = $clog2(LAT_MIN + 2);
    localparam int MW = $clog2(CONFIRM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAT_C  = AW'(LAT_MIN);
    localparam logic [MW-1:0] CONF_C = MW'(CONFIRM);
    localparam logic [TW-1:0] TMO_C  = TW'(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEEK  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    function automatic logic one_hot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    logic          we_s1_q, we_s2_q, we_s3_q;
    logic [5:0]    cur_idx_q, cur_idx_d, prev_idx_q, prev_idx_d;
    logic          cur_vld_q, cur_vld_d, prev_vld_q, prev_vld_d;
    logic [AW-1:0] age_q, age_d;
    logic          hit_vld_q, hit_vld_d;
    logic [5:0]    hit_idx_q, hit_idx_d;
    logic [1:0]    state_q, state_d;
    logic [5:0]    cand_idx_q, cand_idx_d;
    logic          cand_vld_q, cand_vld_d;
    logic [MW-1:0] match_q, match_d, match_nx;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    pos_row_q, pos_row_d, pos_col_q, pos_col_d;
    logic          pos_valid_q, pos_valid_d;

    logic       rise, scan_ok, shift, take_cur, take_prev;
    logic [5:0] scan_idx;

    assign rise     = we_s2_q & ~we_s3_q;
    assign scan_ok  = one_hot8(~scan_row_n_i) & one_hot8(scan_col_i);
    assign scan_idx = {enc8(~scan_row_n_i), enc8(scan_col_i)};
    assign shift    = scan_ok && (!cur_vld_q || (scan_idx != cur_idx_q));

    // Attribution reads the pre-update indices, so a same-cycle scan change cannot steal the hit.
    assign take_cur  = (age_q >= LAT_C) && cur_vld_q;
    assign take_prev = (age_q < LAT_C) && prev_vld_q;

    always_comb begin
        cur_idx_d  = cur_idx_q;
        cur_vld_d  = cur_vld_q;
        prev_idx_d = prev_idx_q;
        prev_vld_d = prev_vld_q;
        age_d      = (age_q == LAT_C) ? age_q : age_q + 1'b1;
        if (shift) begin
            prev_idx_d = cur_idx_q;
            prev_vld_d = cur_vld_q;
            cur_idx_d  = scan_idx;
            cur_vld_d  = 1'b1;
            age_d      = '0;
        end else if (!scan_ok) begin
            cur_vld_d = 1'b0;
        end
        if (!en_i) age_d = '0;

        hit_vld_d = en_i && rise && (take_cur || take_prev);
        hit_idx_d = take_cur ? cur_idx_q : prev_idx_q;
    end

    always_comb begin
        state_d     = state_q;
        cand_idx_d  = cand_idx_q;
        cand_vld_d  = cand_vld_q;
        match_d     = match_q;
        tmo_d       = tmo_q;
        pos_row_d   = pos_row_q;
        pos_col_d   = pos_col_q;
        pos_valid_d = 1'b0;
        match_nx    = match_q;
        if (!en_i) begin
            state_d    = ST_IDLE;
            cand_vld_d = 1'b0;
            match_d    = '0;
            tmo_d      = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_SEEK;
        end else if (hit_vld_q) begin
            tmo_d = '0;
            if (cand_vld_q && (hit_idx_q == cand_idx_q)) begin
                match_nx = match_q + 1'b1;
            end else begin
                cand_idx_d = hit_idx_q;
                cand_vld_d = 1'b1;
                match_nx   = MW'(1);
            end
            // Restart the count after each report so TRACK re-confirms every CONFIRM hits.
            if (match_nx == CONF_C) begin
                pos_row_d   = hit_idx_q[5:3];
                pos_col_d   = hit_idx_q[2:0];
                pos_valid_d = 1'b1;
                match_d     = '0;
                state_d     = ST_TRACK;
            end else begin
                match_d = match_nx;
            end
        end else begin
            if (tmo_q != TMO_C) tmo_d = tmo_q + 1'b1;
            if ((state_q == ST_TRACK) && (tmo_q == TMO_C)) begin
                state_d    = ST_SEEK;
                cand_vld_d = 1'b0;
                match_d    = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_s1_q     <= 1'b0;
            we_s2_q     <= 1'b0;
            we_s3_q     <= 1'b0;
            cur_idx_q   <= '0;
            cur_vld_q   <= 1'b0;
            prev_idx_q  <= '0;
            prev_vld_q  <= 1'b0;
            age_q       <= '0;
            hit_vld_q   <= 1'b0;
            hit_idx_q   <= '0;
            state_q     <= ST_IDLE;
            cand_idx_q  <= '0;
            cand_vld_q  <= 1'b0;
            match_q     <= '0;
            tmo_q       <= '0;
            pos_row_q   <= '0;
            pos_col_q   <= '0;
            pos_valid_q <= 1'b0;
        end else begin
            we_s1_q     <= we_i;
            we_s2_q     <= we_s1_q;
            we_s3_q     <= we_s2_q;
            cur_idx_q   <= cur_idx_d;
            cur_vld_q   <= cur_vld_d;
            prev_idx_q  <= prev_idx_d;
            prev_vld_q  <= prev_vld_d;
            age_q       <= age_d;
            hit_vld_q   <= hit_vld_d;
            hit_idx_q   <= hit_idx_d;
            state_q     <= state_d;
            cand_idx_q  <= cand_idx_d;
            cand_vld_q  <= cand_vld_d;
            match_q     <= match_d;
            tmo_q       <= tmo_d;
            pos_row_q   <= pos_row_d;
            pos_col_q   <= pos_col_d;
            pos_valid_q <= pos_valid_d;
        end
    end

    assign pos_row_o     = pos_row_q;
    assign pos_col_o     = pos_col_q;
    assign pos_valid_o   = pos_valid_q;
    assign pen_present_o = (state_q == ST_TRACK);

endmodule
